dmem_arbiter: RTL and testbench

Shares the single dual-port data bsram between the CPU, button_controller and rect_copy_controller. It replaces the `copy`-driven static muxes in brus16_top with per-port request/grant arbitration, so the CPU and the copy engines can interleave accesses. The `copy` phase from brus16_controller selects the priority order, and an optional starvation guard bounds the wait of low-priority clients. The read and write ports are arbitrated independently, and read-data validity is tracked against the 1-cycle bsram latency.

---
 rtl/dmem_arb_pkg.sv | 39 +++
 rtl/prio_pick.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants and helpers for the data-memory arbiter.
//   - client index constants (CPU, button_controller, rect_copy_controller)
//   - N_CLIENTS and the client index width
//   - prio_order(): priority rotation for a given copy phase, entry 0 is the
//     highest-priority client.
// Also supplies a fallback for the DATA_ADDR_WIDTH macro when the
// surrounding build does not define it.

`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 13
`endif

package dmem_arb_pkg;

  localparam int CLIENT_CPU   = 0;
  localparam int CLIENT_BTN   = 1;
  localparam int CLIENT_RECT  = 2;
  localparam int N_CLIENTS    = 3;
  localparam int CLIENT_IDX_W = $clog2(N_CLIENTS);

  typedef logic [N_CLIENTS-1:0][CLIENT_IDX_W-1:0] prio_order_t;

  // copy=0 : CPU > BTN > RECT ; copy=1 : BTN > RECT > CPU
  function automatic prio_order_t prio_order(input logic copy);
    prio_order_t ord;
    ord = '0;
    if (copy) begin
      ord[0] = CLIENT_IDX_W'(CLIENT_BTN);
      ord[1] = CLIENT_IDX_W'(CLIENT_RECT);
      ord[2] = CLIENT_IDX_W'(CLIENT_CPU);
    end else begin
      ord[0] = CLIENT_IDX_W'(CLIENT_CPU);
      ord[1] = CLIENT_IDX_W'(CLIENT_BTN);
      ord[2] = CLIENT_IDX_W'(CLIENT_RECT);
    end
    return ord;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick: N-way one-hot winner selection for one memory port.
// Ports:
//   cand    in  N         candidates requesting this port
//   starved in  N         clients whose wait reached the starvation limit
//   order   in  N x IDX_W priority order, order[0] = highest priority
//   win     out N         one-hot winner, all zero when there is no candidate
// A starved candidate beats the priority order; among several starved
// candidates the lowest index wins.

module prio_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]            cand,
  input  logic [N-1:0]            starved,
  input  logic [N-1:0][IDX_W-1:0] order,
  output logic [N-1:0]            win
);

  logic [N-1:0]     hungry_s;
  logic [IDX_W-1:0] starve_sel_s;
  logic             starve_hit_s;
  logic [IDX_W-1:0] prio_sel_s;
  logic             prio_hit_s;

  assign hungry_s = cand & starved;

  // Lowest-index starved candidate (scan downwards so the lowest index is the last write)
  always_comb begin
    starve_sel_s = '0;
    starve_hit_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      starve_sel_s = hungry_s[i] ? IDX_W'(i) : starve_sel_s;
      starve_hit_s = starve_hit_s | hungry_s[i];
    end
  end

  // Highest-priority candidate (scan from lowest priority so order[0] is the last write)
  always_comb begin
    prio_sel_s = '0;
    prio_hit_s = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      prio_sel_s = cand[order[k]] ? order[k] : prio_sel_s;
      prio_hit_s = prio_hit_s | cand[order[k]];
    end
  end

  // One-hot winner encoding
  always_comb begin
    win = '0;
    if (starve_hit_s) begin
      win = {{(N-1){1'b0}}, 1'b1} << starve_sel_s;
    end else if (prio_hit_s) begin
      win = {{(N-1){1'b0}}, 1'b1} << prio_sel_s;
    end else begin
      win = '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the dual-port data bsram between the CPU (client 0),
// button_controller (client 1) and rect_copy_controller (client 2).
// The read port and the write port are arbitrated independently; copy
// selects the priority order. Read data returns one cycle after the grant.
// Build option: define DMEM_ARB_STARVE_EN to add per-client wait counters
// that force-grant a client once it has waited STARVE_LIMIT cycles.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   copy              1 = copy engines have priority
//   req/we            per-client request and direction (1 = write)
//   addr/wdata        per-client address / write data, client 0 in the LSBs
//   gnt               per-client grant (combinational, one access per grant)
//   rvalid/rdata      read return, one cycle after the read grant
//   mem_dout_addr     bsram read address, mem_dout bsram read data
//   mem_we/mem_din_addr/mem_din  bsram write port

module dmem_arbiter #(
  parameter int DATA_ADDR_WIDTH = `DATA_ADDR_WIDTH,
  parameter int N_CLIENTS       = 3,
  parameter int STARVE_LIMIT    = 15
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 copy,
  input  logic [N_CLIENTS-1:0]                 req,
  input  logic [N_CLIENTS-1:0]                 we,
  input  logic [N_CLIENTS*DATA_ADDR_WIDTH-1:0] addr,
  input  logic [N_CLIENTS*16-1:0]              wdata,
  output logic [N_CLIENTS-1:0]                 gnt,
  output logic [N_CLIENTS-1:0]                 rvalid,
  output logic [15:0]                          rdata,
  output logic [DATA_ADDR_WIDTH-1:0]           mem_dout_addr,
  input  logic [15:0]                          mem_dout,
  output logic                                 mem_we,
  output logic [DATA_ADDR_WIDTH-1:0]           mem_din_addr,
  output logic [15:0]                          mem_din
);

  import dmem_arb_pkg::*;

  logic [N_CLIENTS-1:0]       rd_cand_s;
  logic [N_CLIENTS-1:0]       wr_cand_s;
  logic [N_CLIENTS-1:0]       starved_s;
  logic [N_CLIENTS-1:0]       rd_win_s;
  logic [N_CLIENTS-1:0]       wr_win_s;
  logic [N_CLIENTS-1:0]       rd_gnt_s;
  logic [N_CLIENTS-1:0]       wr_gnt_s;
  logic [N_CLIENTS-1:0]       gnt_s;
  logic [N_CLIENTS-1:0]       rd_owner_r;
  logic [DATA_ADDR_WIDTH-1:0] rd_addr_s;
  logic [DATA_ADDR_WIDTH-1:0] rd_addr_r;
  prio_order_t                order_s;

  assign rd_cand_s = req & ~we;
  assign wr_cand_s = req & we;
  assign order_s   = prio_order(copy);

  prio_pick #(.N(N_CLIENTS), .IDX_W(CLIENT_IDX_W)) u_rd_pick (
    .cand    (rd_cand_s),
    .starved (starved_s),
    .order   (order_s),
    .win     (rd_win_s)
  );

  prio_pick #(.N(N_CLIENTS), .IDX_W(CLIENT_IDX_W)) u_wr_pick (
    .cand    (wr_cand_s),
    .starved (starved_s),
    .order   (order_s),
    .win     (wr_win_s)
  );

  // Grants are forced off while reset is high, regardless of requests
  always_comb begin
    rd_gnt_s = '0;
    wr_gnt_s = '0;
    if (reset) begin
      rd_gnt_s = '0;
      wr_gnt_s = '0;
    end else begin
      rd_gnt_s = rd_win_s;
      wr_gnt_s = wr_win_s;
    end
  end

  assign gnt_s = rd_gnt_s | wr_gnt_s;
  assign gnt   = gnt_s;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [N_CLIENTS-1:0][CNT_W-1:0] wait_cnt_r;

  // Per-client wait counters: count ungranted request cycles, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (!req[i] || gnt_s[i]) begin
          wait_cnt_r[i] <= '0;
        end else if (wait_cnt_r[i] != CNT_W'(STARVE_LIMIT)) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + CNT_W'(1);
        end else begin
          wait_cnt_r[i] <= wait_cnt_r[i];
        end
      end
    end
  end

  // A client at the limit overrides the priority order on its port
  always_comb begin
    starved_s = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      starved_s[i] = (wait_cnt_r[i] == CNT_W'(STARVE_LIMIT));
    end
  end
`else
  // Pure fixed priority: the limit has no effect in this build
  logic [31:0] starve_limit_unused_s;
  assign starve_limit_unused_s = 32'(STARVE_LIMIT);
  assign starved_s             = '0;
`endif

  // Address/data steering from the port winners; client 0 when there is none
  always_comb begin
    rd_addr_s    = addr[DATA_ADDR_WIDTH-1:0];
    mem_din_addr = addr[DATA_ADDR_WIDTH-1:0];
    mem_din      = wdata[15:0];
    for (int i = 0; i < N_CLIENTS; i++) begin
      rd_addr_s    = rd_win_s[i] ? addr[i*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH] : rd_addr_s;
      mem_din_addr = wr_win_s[i] ? addr[i*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH] : mem_din_addr;
      mem_din      = wr_win_s[i] ? wdata[i*16 +: 16] : mem_din;
    end
  end

  assign mem_we = |wr_gnt_s;

  // The bsram samples the read address in the grant cycle; otherwise hold it
  assign mem_dout_addr = (|rd_gnt_s) ? rd_addr_s : rd_addr_r;

  // Last read address and owner of the read returning next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_r  <= '0;
      rd_owner_r <= '0;
    end else begin
      rd_owner_r <= rd_gnt_s;
      if (|rd_gnt_s) begin
        rd_addr_r <= rd_addr_s;
      end else begin
        rd_addr_r <= rd_addr_r;
      end
    end
  end

  assign rvalid = rd_owner_r;
  assign rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed scoreboard bench for dmem_arbiter.
// A driver keeps per-client request state, applies it each cycle and uses a
// reference model (priority lists, wait counts, shadow memory) to push the
// expected grants and read returns; a monitor on the falling edge pops and
// compares them. A simple read-first bsram model sits on the memory pins.

module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int NC = 3;
  localparam int SL = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              copy;
  logic [NC-1:0]     req;
  logic [NC-1:0]     we;
  logic [NC*AW-1:0]  addr;
  logic [NC*16-1:0]  wdata;
  logic [NC-1:0]     gnt;
  logic [NC-1:0]     rvalid;
  logic [15:0]       rdata;
  logic [AW-1:0]     mem_dout_addr;
  logic [15:0]       mem_dout;
  logic              mem_we;
  logic [AW-1:0]     mem_din_addr;
  logic [15:0]       mem_din;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_ADDR_WIDTH(AW), .N_CLIENTS(NC), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .copy(copy), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout), .mem_we(mem_we),
    .mem_din_addr(mem_din_addr), .mem_din(mem_din)
  );

  // bsram model: 1-cycle read latency, read returns the pre-write contents
  logic [15:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) bram[mem_din_addr] <= mem_din;
    mem_dout <= bram[mem_dout_addr];
  end

  typedef struct {
    logic [NC-1:0] g;
    logic          mw;
    logic [AW-1:0] wa;
    logic [15:0]   wd;
    bit            rst;
  } gexp_t;

  typedef struct {
    logic [NC-1:0] own;
    logic [15:0]   d;
    int            due;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  logic [15:0]   ref_mem [0:(1<<AW)-1];
  bit            pend [NC];
  bit            keep [NC];
  bit            cwe  [NC];
  logic [AW-1:0] cad  [NC];
  logic [15:0]   cwd  [NC];
  int            wt   [NC];
  bit            cp;
  int            cyc = 0;
  int            n_err = 0;
  int            n_checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [15:0] d);
    pend[i] = 1'b1;
    cwe[i]  = w;
    cad[i]  = a;
    cwd[i]  = d;
  endtask

  function automatic bit busy();
    bit b = 1'b0;
    for (int i = 0; i < NC; i++) b |= pend[i];
    return b;
  endfunction

  // Apply one cycle of stimulus and push what the reference model expects
  task automatic step(input bit rst_v);
    gexp_t ge;
    rexp_t re;
    int    order [3];
    int    rw;
    int    ww;
    cyc++;
    reset = rst_v;
    copy  = cp;
    for (int i = 0; i < NC; i++) begin
      req[i]              = pend[i];
      we[i]               = cwe[i];
      addr[i*AW +: AW]    = cad[i];
      wdata[i*16 +: 16]   = cwd[i];
    end
    ge.g = '0; ge.mw = 1'b0; ge.wa = '0; ge.wd = '0; ge.rst = rst_v;
    if (rst_v) begin
      rq.delete();
      for (int i = 0; i < NC; i++) wt[i] = 0;
    end else begin
      if (cp) begin order[0] = 1; order[1] = 2; order[2] = 0; end
      else    begin order[0] = 0; order[1] = 1; order[2] = 2; end
      rw = -1;
      ww = -1;
`ifdef DMEM_ARB_STARVE_EN
      for (int i = 0; i < NC; i++) begin
        if (pend[i] && wt[i] == SL) begin
          if (!cwe[i] && rw < 0) rw = i;
          if (cwe[i] && ww < 0) ww = i;
        end
      end
`endif
      for (int k = 0; k < 3; k++) begin
        if (pend[order[k]]) begin
          if (!cwe[order[k]] && rw < 0) rw = order[k];
          if (cwe[order[k]] && ww < 0) ww = order[k];
        end
      end
      if (rw >= 0) begin
        ge.g[rw] = 1'b1;
        re.own = '0;
        re.own[rw] = 1'b1;
        re.d = ref_mem[cad[rw]];
        re.due = cyc + 1;
        rq.push_back(re);
      end
      if (ww >= 0) begin
        ge.g[ww] = 1'b1;
        ge.mw = 1'b1;
        ge.wa = cad[ww];
        ge.wd = cwd[ww];
        ref_mem[cad[ww]] = cwd[ww];
      end
      for (int i = 0; i < NC; i++) begin
        if (!pend[i] || ge.g[i]) wt[i] = 0;
        else if (wt[i] < SL) wt[i]++;
        if (ge.g[i]) pend[i] = keep[i];
      end
    end
    gq.push_back(ge);
  endtask

  task automatic tick(input bit rst_v);
    @(posedge clk);
    #1;
    step(rst_v);
  endtask

  // Monitor: compare grants every cycle, read returns whenever rvalid shows up
  gexp_t mg;
  rexp_t mr;
  always @(negedge clk) begin
    if (gq.size() > 0) begin
      mg = gq.pop_front();
      chk("gnt", 32'(gnt), 32'(mg.g));
      chk("mem_we", 32'(mem_we), 32'(mg.mw));
      if (mg.mw) begin
        chk("mem_din_addr", 32'(mem_din_addr), 32'(mg.wa));
        chk("mem_din", 32'(mem_din), 32'(mg.wd));
      end
      if (mg.rst) chk("rvalid_in_reset", 32'(rvalid), 32'd0);
    end
    if (rvalid != '0) begin
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", 32'(rvalid), 32'd0);
      end else begin
        mr = rq.pop_front();
        chk("rvalid_owner", 32'(rvalid), 32'(mr.own));
        chk("rdata", 32'(rdata), 32'(mr.d));
        chk("rvalid_cycle", 32'(cyc), 32'(mr.due));
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      mr = rq.pop_front();
      chk("missing_rvalid", 32'(rvalid), 32'(mr.own));
    end
  end

  initial begin
    reset = 1'b1; copy = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    cp = 1'b0;
    for (int a = 0; a < (1 << AW); a++) begin
      bram[a]    = 16'(a * 257) ^ 16'h5A5A;
      ref_mem[a] = 16'(a * 257) ^ 16'h5A5A;
    end
    bram[16]    = 16'h1234;
    ref_mem[16] = 16'h1234;
    for (int i = 0; i < NC; i++) begin
      pend[i] = 1'b0; keep[i] = 1'b0; cwe[i] = 1'b0; cad[i] = '0; cwd[i] = '0; wt[i] = 0;
    end

    // Reset with requests pending: no grants, no writes
    set_req(0, 1'b0, 10'h005, 16'h0000);
    set_req(2, 1'b1, 10'h006, 16'h0606);
    repeat (3) tick(1'b1);
    for (int n = 0; n < 10 && busy(); n++) tick(1'b0);

    // CPU-only read of the preloaded word
    cp = 1'b0;
    set_req(0, 1'b0, 10'h010, 16'h0000);
    tick(1'b0); tick(1'b0);

    // Write conflict in copy phase: button first, CPU next cycle
    cp = 1'b1;
    set_req(0, 1'b1, 10'h040, 16'hAAAA);
    set_req(1, 1'b1, 10'h041, 16'hBBBB);
    tick(1'b0); tick(1'b0); tick(1'b0);

    // Parallel read and write, then read back the written word
    cp = 1'b0;
    set_req(2, 1'b0, 10'h020, 16'h0000);
    set_req(0, 1'b1, 10'h030, 16'hBEEF);
    tick(1'b0);
    set_req(1, 1'b0, 10'h030, 16'h0000);
    tick(1'b0); tick(1'b0);

    // Starvation: button and rect keep reading in copy phase while CPU waits
    cp = 1'b1;
    keep[1] = 1'b1; keep[2] = 1'b1;
    set_req(1, 1'b0, 10'h001, 16'h0000);
    set_req(2, 1'b0, 10'h002, 16'h0000);
    set_req(0, 1'b0, 10'h003, 16'h0000);
    repeat (20) tick(1'b0);
    keep[1] = 1'b0; keep[2] = 1'b0;
    for (int n = 0; n < 10 && busy(); n++) tick(1'b0);

    // Reset in the cycle after a read grant drops the return
    cp = 1'b0;
    set_req(0, 1'b0, 10'h010, 16'h0000);
    tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b0);

    // Copy toggles while a CPU read is in flight
    cp = 1'b0;
    set_req(0, 1'b0, 10'h050, 16'h0000);
    set_req(1, 1'b0, 10'h051, 16'h0000);
    tick(1'b0);
    cp = 1'b1;
    set_req(0, 1'b0, 10'h052, 16'h0000);
    tick(1'b0); tick(1'b0); tick(1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) cp = ~cp;
      for (int i = 0; i < NC; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 16'($urandom));
      end
      tick(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    // Drain outstanding requests and read returns
    for (int n = 0; n < 20 && busy(); n++) tick(1'b0);
    tick(1'b0); tick(1'b0);
    @(posedge clk);
    #1;
    chk("drain_requests", 32'(busy()), 32'd0);
    chk("drain_reads", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
